// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined adder.
// Consumed by pipe_adder_if and pipe_adder.
package pipe_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 16;
    localparam int unsigned DEFAULT_STAGES = 4;

    // Bits handled by each pipeline stage.
    function automatic int unsigned chunk_bits(input int unsigned width,
                                               input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// Port ovf exists only when PIPE_ADDER_OVF_EN is defined.
interface pipe_adder_if import pipe_adder_pkg::*; #(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif

endinterface

// File: rtl/pipe_adder_fa_slice.sv
// Combinational CHUNK-bit ripple-carry adder slice used by each pipeline stage.
module fa_slice #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic c;

    always_comb begin
        s = '0;
        c = ci;
        for (int k = 0; k < CHUNK; k++) begin
            s[k] = a[k] ^ b[k] ^ c;
            c    = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
        end
        co = c;
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder: STAGES slices of WIDTH/STAGES bits, global valid/ready stall.
// Define PIPE_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipe_adder import pipe_adder_pkg::*; #(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input logic         clk,
    input logic         rst,
    pipe_adder_if.slave io
);

    localparam int unsigned CHUNK = chunk_bits(WIDTH, STAGES);

    if (WIDTH < 1 || WIDTH > 64 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0)
    begin : g_bad_params
        $fatal(1, "pipe_adder: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
    end

    logic adv;

    assign adv         = io.out_ready || !io.out_valid;
    assign io.in_ready = adv;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam int unsigned LO  = i * CHUNK;
        // Operand bits not yet consumed when the beat reaches this stage.
        localparam int unsigned REM = WIDTH - LO;

        logic [REM-1:0]      a_in;
        logic [REM-1:0]      b_in;
        logic                c_in;
        logic                v_in;
        logic [CHUNK-1:0]    s_slice;
        logic                co_slice;
        logic [LO+CHUNK-1:0] sum_d;
        logic [LO+CHUNK-1:0] sum_q;
        logic                valid_q;
        logic                carry_q;

        if (i == 0) begin : g_src
            assign a_in  = io.a;
            assign b_in  = io.b;
            assign c_in  = io.cin;
            assign v_in  = io.in_valid;
            assign sum_d = s_slice;
        end else begin : g_src
            assign a_in  = g_stage[i-1].g_ops.a_q;
            assign b_in  = g_stage[i-1].g_ops.b_q;
            assign c_in  = g_stage[i-1].carry_q;
            assign v_in  = g_stage[i-1].valid_q;
            assign sum_d = {s_slice, g_stage[i-1].sum_q};
        end

        fa_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a  (a_in[CHUNK-1:0]),
            .b  (b_in[CHUNK-1:0]),
            .ci (c_in),
            .s  (s_slice),
            .co (co_slice)
        );

        // Data only loads with a real beat so idle inputs never reach the outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= v_in;
                if (v_in) begin
                    carry_q <= co_slice;
                    sum_q   <= sum_d;
                end
            end
        end

        if (REM > CHUNK) begin : g_ops
            logic [REM-CHUNK-1:0] a_q;
            logic [REM-CHUNK-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && v_in) begin
                    a_q <= a_in[REM-1:CHUNK];
                    b_q <= b_in[REM-1:CHUNK];
                end
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        if (i == STAGES - 1) begin : g_ovf
            logic ovf_q;

            // Carry into the MSB is recovered from the MSB sum and operand bits.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv && v_in) begin
                    ovf_q <= s_slice[CHUNK-1] ^ a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ co_slice;
                end
            end
        end
`endif
    end

    assign io.out_valid = g_stage[STAGES-1].valid_q;
    assign io.sum       = g_stage[STAGES-1].sum_q;
    assign io.cout      = g_stage[STAGES-1].carry_q;
`ifdef PIPE_ADDER_OVF_EN
    assign io.ovf       = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule
